// File: rtl/score_feeder_pkg.sv
// Shared constants and state type for the score feeder that sits in front of the max-comparator tree.
// Score width, class count and tree latency live here so the tree and the feeder agree.
package score_feeder_pkg;

    localparam int DATA_LEN_DFLT  = 8;
    localparam int NUM_CLASS_DFLT = 10;
    localparam int TREE_LAT_DFLT  = 4;
    localparam int IDX_W          = 4;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } feeder_state_e;

    function automatic logic [IDX_W-1:0] lane_index(input int k);
        return IDX_W'(k);
    endfunction

endpackage

// File: rtl/score_feeder_if.sv
// Score stream, comparator-tree lanes and class-result handshake of the score feeder.
// Optional out_score signal exists only when SCORE_FEEDER_SCORE_OUT_EN is defined.
interface score_feeder_if
    import score_feeder_pkg::*;
#(
    parameter int NUM_CLASS = NUM_CLASS_DFLT,
    parameter int DATA_LEN  = DATA_LEN_DFLT
);
    logic                              in_valid;
    logic                              in_ready;
    logic signed [DATA_LEN-1:0]        in_data;
    logic [NUM_CLASS*DATA_LEN-1:0]     lane_data;
    logic [NUM_CLASS*IDX_W-1:0]        lane_num;
    logic [IDX_W-1:0]                  tree_num;
    logic signed [DATA_LEN-1:0]        tree_q;
    logic                              out_valid;
    logic                              out_ready;
    logic [IDX_W-1:0]                  out_num;
`ifdef SCORE_FEEDER_SCORE_OUT_EN
    logic signed [DATA_LEN-1:0]        out_score;

    modport slave (
        input  in_valid, in_data, tree_num, tree_q, out_ready,
        output in_ready, lane_data, lane_num, out_valid, out_num, out_score
    );
    modport master (
        output in_valid, in_data, tree_num, tree_q, out_ready,
        input  in_ready, lane_data, lane_num, out_valid, out_num, out_score
    );
`else
    modport slave (
        input  in_valid, in_data, tree_num, tree_q, out_ready,
        output in_ready, lane_data, lane_num, out_valid, out_num
    );
    modport master (
        output in_valid, in_data, tree_num, tree_q, out_ready,
        input  in_ready, lane_data, lane_num, out_valid, out_num
    );
`endif
endinterface

// File: rtl/score_feeder.sv
// Collects one frame of class scores into parallel tagged lanes, waits out the comparator
// tree latency and presents the winning index. Optional SCORE_FEEDER_SCORE_OUT_EN adds out_score.
module score_feeder
    import score_feeder_pkg::*;
#(
    parameter int NUM_CLASS = NUM_CLASS_DFLT,
    parameter int DATA_LEN  = DATA_LEN_DFLT,
    parameter int TREE_LAT  = TREE_LAT_DFLT
) (
    input  logic           clk,
    input  logic           rst_n,
    score_feeder_if.slave  bus
);
    localparam logic [3:0] CNT_LAST  = 4'(NUM_CLASS - 1);
    localparam logic [3:0] WAIT_LAST = 4'(TREE_LAT - 1);

    feeder_state_e                 state_r, state_s;
    logic [3:0]                    cnt_r, cnt_s;
    logic [3:0]                    wait_cnt_r, wait_cnt_s;
    logic                          in_ready_r;
    logic                          out_valid_r;
    logic [IDX_W-1:0]              out_num_r;
    logic [NUM_CLASS*DATA_LEN-1:0] lane_r;
    logic                          lane_we_s;
    logic                          capture_s;
    logic                          release_s;

    // Next-state, counters and strobes of the FILL/WAIT/HOLD sequencer
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        wait_cnt_s = wait_cnt_r;
        lane_we_s  = 1'b0;
        capture_s  = 1'b0;
        release_s  = 1'b0;
        case (state_r)
            FILL: begin
                if (bus.in_valid && in_ready_r) begin
                    lane_we_s = 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        cnt_s      = 4'd0;
                        wait_cnt_s = 4'd0;
                        state_s    = WAIT;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    capture_s  = 1'b1;
                    wait_cnt_s = 4'd0;
                    state_s    = HOLD;
                end else begin
                    wait_cnt_s = wait_cnt_r + 4'd1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    release_s = 1'b1;
                    state_s   = FILL;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s    = FILL;
                cnt_s      = 4'd0;
                wait_cnt_s = 4'd0;
            end
        endcase
    end

    // Sequencer state, lane storage and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            cnt_r       <= 4'd0;
            wait_cnt_r  <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_num_r   <= '0;
            lane_r      <= '0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            wait_cnt_r <= wait_cnt_s;
            in_ready_r <= (state_s == FILL);
            if (lane_we_s) begin
                lane_r[int'(cnt_r)*DATA_LEN +: DATA_LEN] <= bus.in_data;
            end
            if (capture_s) begin
                out_valid_r <= 1'b1;
                out_num_r   <= bus.tree_num;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

`ifdef SCORE_FEEDER_SCORE_OUT_EN
    logic signed [DATA_LEN-1:0] out_score_r;

    // Winning score captured alongside the winning index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_score_r <= '0;
        end else if (capture_s) begin
            out_score_r <= bus.tree_q;
        end
    end

    assign bus.out_score = out_score_r;
`else
    logic unused_tree_q;
    assign unused_tree_q = ^bus.tree_q;
`endif

    // Lane order must match score order: the tree favours the higher lane on ties
    for (genvar k = 0; k < NUM_CLASS; k++) begin : g_lane_num
        assign bus.lane_num[k*IDX_W +: IDX_W] = lane_index(k);
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_num   = out_num_r;
    assign bus.lane_data = lane_r;

endmodule

// File: tb/tb_score_feeder.sv
// Randomized scoreboard bench for score_feeder with a behavioural comparator tree
// (higher lane wins on equal scores) driving tree_num/tree_q.
module tb_score_feeder;
    import score_feeder_pkg::*;

    localparam int NC = NUM_CLASS_DFLT;
    localparam int DL = DATA_LEN_DFLT;
    localparam int TL = TREE_LAT_DFLT;

    typedef struct {
        logic [3:0]          num;
        logic signed [DL-1:0] score;
        int                  due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    score_feeder_if #(.NUM_CLASS(NC), .DATA_LEN(DL)) bus();

    score_feeder #(.NUM_CLASS(NC), .DATA_LEN(DL), .TREE_LAT(TL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int res_xfer_cyc = -1;
    bit b2b      = 1'b0;
    bit busy     = 1'b0;
    bit seen_valid = 1'b0;
    exp_t exp_q[$];
    logic signed [DL-1:0] cur_frame[$];
    logic [NC*DL-1:0] held_lanes;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // behavioural comparator tree: argmax with higher lane kept on ties, TL-1 register stages
    logic [3:0]          tn_pipe [TL-1];
    logic signed [DL-1:0] tq_pipe [TL-1];

    function automatic logic [3+DL:0] tree_pick(input logic [NC*DL-1:0] lanes);
        logic signed [DL-1:0] best;
        logic [3:0] idx;
        best = $signed(lanes[DL-1:0]);
        idx  = 4'd0;
        for (int k = 1; k < NC; k++) begin
            if ($signed(lanes[k*DL +: DL]) >= best) begin
                best = $signed(lanes[k*DL +: DL]);
                idx  = 4'(k);
            end
        end
        return {idx, best};
    endfunction

    always @(posedge clk) begin
        {tn_pipe[0], tq_pipe[0]} <= tree_pick(bus.lane_data);
        for (int s = 1; s < TL-1; s++) begin
            tn_pipe[s] <= tn_pipe[s-1];
            tq_pipe[s] <= tq_pipe[s-1];
        end
    end
    assign bus.tree_num = tn_pipe[TL-2];
    assign bus.tree_q   = tq_pipe[TL-2];

    // reference: largest score; among equals, the last class index
    function automatic exp_t ref_result(input logic signed [DL-1:0] f[$], input int due);
        exp_t e;
        int mx;
        mx = -100000;
        foreach (f[k]) if (int'(f[k]) > mx) mx = int'(f[k]);
        e.num = 4'd0;
        foreach (f[k]) if (int'(f[k]) == mx) e.num = 4'(k);
        e.score = DL'(mx);
        e.due = due;
        return e;
    endfunction

    // input/output transfer monitor (posedge)
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            cur_frame.delete();
            exp_q.delete();
            busy = 1'b0;
            seen_valid = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                busy = 1'b0;
                seen_valid = 1'b0;
                res_xfer_cyc = cyc;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (cur_frame.size() == 0 && b2b && res_xfer_cyc >= 0) begin
                    chk("b2b_first_beat", 256'(cyc), 256'(res_xfer_cyc + 1));
                    res_xfer_cyc = -1;
                end
                cur_frame.push_back(bus.in_data);
                if (cur_frame.size() == NC) begin
                    exp_q.push_back(ref_result(cur_frame, cyc + TL));
                    for (int k = 0; k < NC; k++) held_lanes[k*DL +: DL] = cur_frame[k];
                    busy = 1'b1;
                    cur_frame.delete();
                end
            end
        end
    end

    // output checker (negedge)
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", 256'(bus.in_ready), 256'(!busy));
            if (busy) chk("lanes_stable", 256'(bus.lane_data), 256'(held_lanes));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 256'(bus.out_valid), 256'(0));
                end else begin
                    if (!seen_valid) begin
                        chk("latency", 256'(cyc), 256'(exp_q[0].due));
                        seen_valid = 1'b1;
                    end
                    chk("out_num", 256'(bus.out_num), 256'(exp_q[0].num));
`ifdef SCORE_FEEDER_SCORE_OUT_EN
                    chk("out_score", 256'(bus.out_score), 256'(exp_q[0].score));
`endif
                end
            end
        end
        cyc++;
    end

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
        chk("rst_out_num", 256'(bus.out_num), 256'(0));
        chk("rst_lanes", 256'(bus.lane_data), 256'(0));
`ifdef SCORE_FEEDER_SCORE_OUT_EN
        chk("rst_out_score", 256'(bus.out_score), 256'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic signed [DL-1:0] s [NC], input int n, input int gap);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 300) begin
            @(negedge clk);
            guard++;
            if ($urandom_range(99) < gap) begin
                bus.in_valid = 1'b0;
                bus.in_data  = DL'($urandom);
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = s[i];
                if (bus.in_ready) i++;
            end
        end
        if (i < n) chk("send_timeout", 256'(i), 256'(n));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int hold);
        int guard = 0;
        while (!bus.out_valid && guard < 60) begin
            @(negedge clk);
            guard++;
            bus.in_valid = 1'($urandom_range(1));
            bus.in_data  = DL'($urandom);
        end
        if (!bus.out_valid) chk("result_timeout", 256'(0), 256'(1));
        repeat (hold) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(1));
            bus.in_data  = DL'($urandom);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic void rand_frame(output logic signed [DL-1:0] f [NC], input bit narrow);
        for (int k = 0; k < NC; k++)
            f[k] = narrow ? DL'(int'($urandom_range(7)) - 4) : DL'($urandom);
    endfunction

    logic signed [DL-1:0] fr [NC];
    logic [NC*4-1:0] exp_lane_num;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < NC; k++) exp_lane_num[k*4 +: 4] = 4'(k);
        chk("lane_num", 256'(bus.lane_num), 256'(exp_lane_num));

        // reset after 3 beats discards the partial frame
        rand_frame(fr, 1'b0);
        send_frame(fr, 3, 0);
        do_reset();
        rand_frame(fr, 1'b0);
        send_frame(fr, NC, 0);
        drain(0);

        fr = '{8'sd5, -8'sd3, 8'sd7, 8'sd2, 8'sd0, -8'sd8, 8'sd1, 8'sd6, 8'sd4, 8'sd3};
        send_frame(fr, NC, 0);
        drain(0);

        for (int k = 0; k < NC; k++) fr[k] = -8'sd100;
        send_frame(fr, NC, 0);
        drain(0);

        for (int k = 0; k < NC; k++) fr[k] = 8'sd0;
        fr[NC-1] = 8'sd127;
        send_frame(fr, NC, 0);
        drain(0);

        for (int k = 0; k < NC; k++) fr[k] = DL'(-1 - int'($urandom_range(100)));
        fr[0] = 8'sd50;
        send_frame(fr, NC, 0);
        drain(0);

        // random in_valid gaps, result held 6 cycles
        for (int t = 0; t < 4; t++) begin
            rand_frame(fr, t[0]);
            send_frame(fr, NC, 50);
            drain(6);
        end

        // back-to-back frames with out_ready held high
        bus.out_ready = 1'b1;
        res_xfer_cyc = -1;
        b2b = 1'b1;
        rand_frame(fr, 1'b0);
        send_frame(fr, NC, 0);
        rand_frame(fr, 1'b1);
        send_frame(fr, NC, 0);
        repeat (12) @(negedge clk);
        bus.out_ready = 1'b0;
        b2b = 1'b0;

        for (int t = 0; t < 3; t++) begin
            rand_frame(fr, t[0]);
            send_frame(fr, NC, 30);
            drain(int'($urandom_range(4)));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 256'(exp_q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
